cellrv32_xirq_filter: RTL

CELLRV32_XIRQ_FILTER -- requirements
Module: cellrv32_xirq_filter

---
 rtl/cellrv32_xirq_filter.sv | 74 +++++++
 1 files changed

// File: rtl/cellrv32_xirq_filter.sv
// cellrv32_xirq_filter: per-channel synchronizer and stability filter for external interrupt pins.
//   clk_i        : clock, rising edge
//   rstn_i       : asynchronous active-low reset
//   en_i         : per-channel filter enable; a disabled channel idles at INIT_LEVEL
//   xirq_raw_i   : asynchronous raw interrupt pins
//   glitch_clr_i : synchronous clear of the glitch counter
//   xirq_o       : filtered levels
//   change_o     : one-cycle pulse on every accepted level change
//   glitch_cnt_o : saturating count of cycles with a rejected glitch
//                  (only with XIRQ_FILT_GLITCH_CNT_EN, otherwise 0)
module cellrv32_xirq_filter #(
  parameter int          NUM_CH     = 8,
  parameter int          FILT_LEN   = 4,
  parameter logic [31:0] INIT_LEVEL = '0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] en_i,
  input  logic [31:0] xirq_raw_i,
  input  logic        glitch_clr_i,
  output logic [31:0] xirq_o,
  output logic [31:0] change_o,
  output logic [7:0]  glitch_cnt_o
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [31:0] glitch;
  for (genvar i = 0; i < 32; i++) begin : g_ch
    if (i < NUM_CH) begin : g_act
      logic sync1, sync2, lvl, chg, en, diff, last;
      logic [CW-1:0] cnt;
      assign en   = en_i[i];
      assign diff = sync2 != lvl;
      assign last = cnt == CW'(FILT_LEN - 1);
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          sync1 <= INIT_LEVEL[i];
          sync2 <= INIT_LEVEL[i];
          lvl   <= INIT_LEVEL[i];
          cnt   <= '0;
          chg   <= 1'b0;
        end else begin
          sync1 <= xirq_raw_i[i];
          sync2 <= sync1;
          lvl   <= !en ? INIT_LEVEL[i] : (diff && last) ? sync2 : lvl;
          cnt   <= (!en || !diff || last) ? '0 : cnt + CW'(1);
          chg   <= en && diff && last;
        end
      end
      // the input fell back to the current level before the count completed
      assign glitch[i]   = en && !diff && (cnt != '0);
      assign xirq_o[i]   = lvl;
      assign change_o[i] = chg;
    end else begin : g_off
      logic unused_in;
      assign unused_in   = en_i[i] ^ xirq_raw_i[i];
      assign xirq_o[i]   = 1'b0;
      assign change_o[i] = 1'b0;
      assign glitch[i]   = 1'b0;
    end
  end
`ifdef XIRQ_FILT_GLITCH_CNT_EN
  logic [7:0] gcnt;
  // one increment per cycle however many channels glitched; clear wins
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) gcnt <= '0;
    else gcnt <= glitch_clr_i ? '0 : ((|glitch) && gcnt != 8'hFF) ? gcnt + 8'd1 : gcnt;
  end
  assign glitch_cnt_o = gcnt;
`else
  logic unused_clr;
  assign unused_clr   = glitch_clr_i ^ (|glitch);
  assign glitch_cnt_o = '0;
`endif
endmodule
